fir_frame_collector: RTL and testbench

Stream sink on the fir output interface (fir_d / fir_valid). Packs consecutive signed 16-bit filter samples into 16-sample frames for the downstream FFT stage. Offers each frame on a valid/ready handshake with double buffering. Tracks frame index within the 1024-sample stream. The FIR has no backpressure, so dropped frames are flagged rather than stalled.

---
 rtl/fir_frame_collector_pkg.sv | 17 +
 rtl/fir_frame_collector_counter.sv | 30 +++
 rtl/fir_frame_collector.sv | 126 ++++++++++++
 tb/tb_fir_frame_collector.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_frame_collector_pkg.sv
// Shared constants and output-register state encoding for the FIR frame collector.
package fir_frame_collector_pkg;

    localparam int DATA_W      = 16;
    localparam int FRAME_LEN   = 16;
    localparam int STREAM_LEN  = 1024;
    localparam int FRAME_CNT   = STREAM_LEN / FRAME_LEN;
    localparam int FRAME_CNT_W = $clog2(FRAME_CNT);
    localparam int FILL_W      = $clog2(FRAME_LEN);

    // Output register occupancy: EMPTY has nothing to offer, FULL presents a frame.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/fir_frame_collector_counter.sv
// Modulo-MOD up counter with enable and synchronous clear; wrap flags the
// enabled cycle in which the count rolls back to zero.
module frame_counter
    import fir_frame_collector_pkg::*;
#(
    parameter int W   = FILL_W,
    parameter int MOD = FRAME_LEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = en && (count == W'(MOD - 1));

    // Count enabled cycles, returning to zero after MOD of them or on clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/fir_frame_collector.sv
// Packs the FIR sample stream into fixed-length frames and offers each frame
// on a valid/ready handshake. A separate fill buffer keeps collecting while
// the output register waits, so one frame of slack exists before a drop.
module fir_frame_collector
    import fir_frame_collector_pkg::*;
#(
    parameter int DATA_W     = fir_frame_collector_pkg::DATA_W,
    parameter int FRAME_LEN  = fir_frame_collector_pkg::FRAME_LEN,
    parameter int STREAM_LEN = fir_frame_collector_pkg::STREAM_LEN
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic signed [DATA_W-1:0]                             fir_d,
    input  logic                                                 fir_valid,
    input  logic                                                 clear,
    input  logic                                                 frame_ready,
    output logic                                                 frame_valid,
    output logic        [FRAME_LEN*DATA_W-1:0]                   frame_data,
    output logic        [$clog2(STREAM_LEN/FRAME_LEN)-1:0]       frame_idx,
    output logic                                                 frame_last,
    output logic                                                 overflow
);

    localparam int FRAME_CNT   = STREAM_LEN / FRAME_LEN;
    localparam int FRAME_CNT_W = $clog2(FRAME_CNT);
    localparam int FILL_W      = $clog2(FRAME_LEN);

    logic        [FILL_W-1:0]           fill_cnt;
    logic                               fill_wrap;
    logic        [FRAME_CNT_W-1:0]      frame_cnt;
    logic                               frame_cnt_wrap;
    logic signed [DATA_W-1:0]           fill_buf [FRAME_LEN];
    logic        [FRAME_LEN*DATA_W-1:0] done_frame;
    out_state_t                         state;

    // Slot pointer into the fill buffer; wraps exactly when a frame completes.
    frame_counter #(
        .W   (FILL_W),
        .MOD (FRAME_LEN)
    ) u_fill_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .en    (fir_valid),
        .count (fill_cnt),
        .wrap  (fill_wrap)
    );

    // Position of the next completed frame within the stream; advances on
    // every completion, including dropped ones, so indices stay aligned.
    frame_counter #(
        .W   (FRAME_CNT_W),
        .MOD (FRAME_CNT)
    ) u_frame_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .en    (fill_wrap),
        .count (frame_cnt),
        .wrap  (frame_cnt_wrap)
    );

    // Fill buffer: pure data storage, each accepted sample lands in its slot.
    always_ff @(posedge clk) begin
        if (fir_valid) begin
            fill_buf[fill_cnt] <= fir_d;
        end
    end

    // Completed frame as seen at the edge of the final sample: the last slot
    // comes straight from the input since it is not yet in the fill buffer.
    always_comb begin
        done_frame = '0;
        for (int k = 0; k < FRAME_LEN - 1; k++) begin
            done_frame[k*DATA_W +: DATA_W] = fill_buf[k];
        end
        done_frame[(FRAME_LEN-1)*DATA_W +: DATA_W] = fir_d;
    end

    // Output register: loads completed frames, holds them until handshake,
    // and drops a completion that arrives while a frame is still unaccepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            frame_data <= '0;
            frame_idx  <= '0;
            frame_last <= 1'b0;
            overflow   <= 1'b0;
        end else if (clear) begin
            state      <= EMPTY;
            frame_data <= '0;
            frame_idx  <= '0;
            frame_last <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (fill_wrap) begin
                        state      <= FULL;
                        frame_data <= done_frame;
                        frame_idx  <= frame_cnt;
                        frame_last <= frame_cnt_wrap;
                    end
                end
                FULL: begin
                    if (fill_wrap && frame_ready) begin
                        frame_data <= done_frame;
                        frame_idx  <= frame_cnt;
                        frame_last <= frame_cnt_wrap;
                    end else if (fill_wrap) begin
                        overflow <= 1'b1;
                    end else if (frame_ready) begin
                        state      <= EMPTY;
                        frame_last <= 1'b0;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    assign frame_valid = (state == FULL);

endmodule

// File: tb/tb_fir_frame_collector.sv
// Scoreboard bench for fir_frame_collector: a reference model predicts each
// frame the collector should present; entries are compared every cycle while
// presented and retired on handshake.
module tb_fir_frame_collector;

    logic               clk;
    logic               rst;
    logic signed [15:0] fir_d;
    logic               fir_valid;
    logic               clear;
    logic               frame_ready;
    logic               frame_valid;
    logic [255:0]       frame_data;
    logic [5:0]         frame_idx;
    logic               frame_last;
    logic               overflow;

    typedef struct {
        logic [255:0] data;
        int           idx;
    } exp_t;

    exp_t        sb [$];
    logic [15:0] m_buf [16];
    int          m_fill;
    int          m_fcnt;
    bit          m_ovf;

    int          total;
    int          bad;
    int          n_acc;
    int          n_last;

    bit          rv;
    bit          rr;
    bit          rc;
    logic [15:0] rd;

    fir_frame_collector dut (
        .clk         (clk),
        .rst         (rst),
        .fir_d       (fir_d),
        .fir_valid   (fir_valid),
        .clear       (clear),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_idx   (frame_idx),
        .frame_last  (frame_last),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_fill = 0;
        m_fcnt = 0;
        m_ovf  = 1'b0;
        sb.delete();
    endtask

    task automatic model_step(input bit v, input logic [15:0] d, input bit r, input bit c);
        exp_t e;
        if (c) begin
            model_reset();
            return;
        end
        if (r && sb.size() != 0) void'(sb.pop_front());
        if (v) begin
            m_buf[m_fill] = d;
            if (m_fill == 15) begin
                for (int k = 0; k < 16; k++) e.data[k*16 +: 16] = m_buf[k];
                e.idx = m_fcnt;
                if (sb.size() == 0) sb.push_back(e);
                else m_ovf = 1'b1;
                m_fcnt = (m_fcnt + 1) % 64;
                m_fill = 0;
            end else begin
                m_fill++;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("frame_valid", 256'(frame_valid), 256'(sb.size() != 0));
        check_eq("overflow", 256'(overflow), 256'(m_ovf));
        if (sb.size() != 0) begin
            check_eq("frame_data", frame_data, sb[0].data);
            check_eq("frame_idx", 256'(frame_idx), 256'(sb[0].idx));
            check_eq("frame_last", 256'(frame_last), 256'(sb[0].idx == 63));
        end else begin
            check_eq("frame_last_idle", 256'(frame_last), 256'(0));
        end
    endtask

    task automatic step(input bit v, input logic [15:0] d, input bit r, input bit c);
        @(negedge clk);
        check_outputs();
        if (r && frame_valid) begin
            n_acc++;
            if (frame_last) n_last++;
        end
        fir_valid   = v;
        fir_d       = d;
        frame_ready = r;
        clear       = c;
        model_step(v, d, r, c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        fir_valid   = 1'b0;
        frame_ready = 1'b0;
        clear       = 1'b0;
        fir_d       = '0;
        model_reset();
        #2;
        check_eq("rst_valid", 256'(frame_valid), 256'(0));
        check_eq("rst_data", frame_data, 256'(0));
        check_eq("rst_idx", 256'(frame_idx), 256'(0));
        check_eq("rst_ovf", 256'(overflow), 256'(0));
        check_eq("rst_last", 256'(frame_last), 256'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        n_acc       = 0;
        n_last      = 0;
        rst         = 1'b1;
        fir_valid   = 1'b0;
        fir_d       = '0;
        clear       = 1'b0;
        frame_ready = 1'b0;
        model_reset();

        // ramp 0..15, always ready
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
        repeat (3) step(1'b0, 16'h0, 1'b1, 1'b0);

        // gapped negative samples -1..-16
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 16'(-(i + 1)), 1'b1, 1'b0);
            step(1'b0, 16'h5A5A, 1'b1, 1'b0);
        end
        repeat (3) step(1'b0, 16'h0, 1'b1, 1'b0);

        // back-pressure hold for 10 cycles, then accept
        for (int i = 0; i < 16; i++) step(1'b1, 16'(16'h100 + i), 1'b0, 1'b0);
        repeat (10) step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        check_eq("bp_valid_after", 256'(frame_valid), 256'(0));
        check_eq("bp_ovf", 256'(overflow), 256'(0));

        // overflow: two completions without ready
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check_eq("ovf_set", 256'(overflow), 256'(1));
        check_eq("ovf_keep_idx", 256'(frame_idx), 256'(0));
        check_eq("ovf_keep_slot15", 256'(frame_data[255:240]), 256'(15));
        step(1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 32; i < 48; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check_eq("ovf_next_idx", 256'(frame_idx), 256'(2));
        check_eq("ovf_next_slot0", 256'(frame_data[15:0]), 256'(32));
        step(1'b0, 16'h0, 1'b1, 1'b0);

        // accept in the same cycle as the next completion
        do_reset();
        for (int i = 0; i < 31; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        step(1'b1, 16'(31), 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check_eq("same_cyc_valid", 256'(frame_valid), 256'(1));
        check_eq("same_cyc_idx", 256'(frame_idx), 256'(1));
        check_eq("same_cyc_ovf", 256'(overflow), 256'(0));
        step(1'b0, 16'h0, 1'b1, 1'b0);

        // full stream with wrap
        do_reset();
        n_acc  = 0;
        n_last = 0;
        for (int i = 0; i < 1040; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
        repeat (3) step(1'b0, 16'h0, 1'b1, 1'b0);
        check_eq("stream_frames", 256'(n_acc), 256'(65));
        check_eq("stream_last_cnt", 256'(n_last), 256'(1));

        // reset mid-frame discards the partial frame
        for (int i = 0; i < 5; i++) step(1'b1, 16'(500 + i), 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 16'(700 + i), 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check_eq("midrst_slot0", 256'(frame_data[15:0]), 256'(700));
        step(1'b0, 16'h0, 1'b1, 1'b0);

        // clear wins over a simultaneous sample and handshake
        for (int i = 0; i < 32; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        step(1'b1, 16'(99), 1'b1, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check_eq("clr_valid", 256'(frame_valid), 256'(0));
        check_eq("clr_data", frame_data, 256'(0));
        check_eq("clr_ovf", 256'(overflow), 256'(0));
        for (int i = 0; i < 16; i++) step(1'b1, 16'(16'h8000 + i), 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check_eq("clr_idx", 256'(frame_idx), 256'(0));
        step(1'b0, 16'h0, 1'b1, 1'b0);

        // random traffic with occasional clear
        for (int n = 0; n < 600; n++) begin
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 2) == 0);
            rc = ($urandom_range(0, 199) == 0);
            rd = 16'($urandom);
            step(rv, rd, rr, rc);
        end
        repeat (3) step(1'b0, 16'h0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
